// File: rtl/ob_arb_pkg.sv
// Shared types and sizing for the output-buffer port arbiter.
package ob_arb_pkg;
  localparam int unsigned WIDTH      = 8;
  localparam int unsigned COL        = 4;
  localparam int unsigned O_SIZE     = 256;
  localparam int unsigned AW         = $clog2(O_SIZE);
  localparam int unsigned DW         = COL * WIDTH;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned HI_WM      = 3;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [AW-1:0]             addr;
    logic [COL-1:0][WIDTH-1:0] data;
  } ob_wr_entry_t;
endpackage

// File: rtl/ob_port_arbiter_if.sv
// Array-write, host-read and SRAM-pin bundle for ob_port_arbiter.
interface ob_port_arbiter_if;
  import ob_arb_pkg::*;

  logic          wr_valid_i;
  logic [AW-1:0] wr_addr_i;
  logic [DW-1:0] wr_data_i;
  logic          rd_req_i;
  logic [AW-1:0] rd_addr_i;
  logic          rd_gnt_o;
  logic          rd_valid_o;
  logic [DW-1:0] rd_data_o;
  logic          mem_cenb_o;
  logic          mem_wenb_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic [DW-1:0] mem_data_i;

  modport slave (
    input  wr_valid_i, wr_addr_i, wr_data_i, rd_req_i, rd_addr_i, mem_data_i,
    output rd_gnt_o, rd_valid_o, rd_data_o, mem_cenb_o, mem_wenb_o, mem_addr_o, mem_data_o
  );

  modport master (
    output wr_valid_i, wr_addr_i, wr_data_i, rd_req_i, rd_addr_i, mem_data_i,
    input  rd_gnt_o, rd_valid_o, rd_data_o, mem_cenb_o, mem_wenb_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/ob_wr_fifo.sv
// Circular write FIFO with flush, occupancy and an address match against all valid entries.
module ob_wr_fifo
  import ob_arb_pkg::*;
#(
  parameter int unsigned Depth = FIFO_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  ob_wr_entry_t             entry_i,
  input  logic                     pop_i,
  input  logic [AW-1:0]            match_addr_i,
  output ob_wr_entry_t             head_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     empty_o,
  output logic                     match_o,
  output logic                     drop_o
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  ob_wr_entry_t        mem_q [Depth];
  logic [PtrW-1:0]     wptr_q, rptr_q;
  logic [CntW-1:0]     count_q;
  logic                full, do_pop, push_ok;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push_i && (!full || do_pop);
  assign drop_o  = push_i && full && !do_pop && !clear_i;
  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

  always_comb begin
    logic [PtrW-1:0] offs;
    match_o = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      offs = PtrW'(i) - rptr_q;
      if ((CntW'(offs) < count_q) && (mem_q[i].addr == match_addr_i)) match_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok && !clear_i) mem_q[wptr_q] <= entry_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({push_ok, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/ob_port_arbiter.sv
// Shares the output-buffer SRAM port between buffered array writes and host reads.
module ob_port_arbiter
  import ob_arb_pkg::*;
#(
  parameter int unsigned FifoDepth = FIFO_DEPTH,
  parameter int unsigned HiWm      = HI_WM
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       clear_i,
  ob_port_arbiter_if.slave           bus,
  output logic [$clog2(FifoDepth):0] fifo_count_o,
  output logic                       idle_o,
  output logic                       overflow_o
);
  localparam int unsigned CntW = $clog2(FifoDepth) + 1;

  ob_wr_entry_t    head, push_entry;
  logic [CntW-1:0] count;
  logic            empty, hit, drop, wr_win, rd_win;
  logic            rd_valid_q, overflow_q;

  assign push_entry.addr = bus.wr_addr_i;
  assign push_entry.data = bus.wr_data_i;

  ob_wr_fifo #(
    .Depth (FifoDepth)
  ) u_wr_fifo (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .clear_i      (clear_i),
    .push_i       (bus.wr_valid_i),
    .entry_i      (push_entry),
    .pop_i        (wr_win),
    .match_addr_i (bus.rd_addr_i),
    .head_o       (head),
    .count_o      (count),
    .empty_o      (empty),
    .match_o      (hit),
    .drop_o       (drop)
  );

  // A read that hits a pending write waits so it always sees the newest data.
  always_comb begin
    wr_win         = !empty && ((count >= CntW'(HiWm)) || (bus.rd_req_i && hit) ||
                                !bus.rd_req_i);
    rd_win         = bus.rd_req_i && !wr_win;
    bus.rd_gnt_o   = rd_win;
    bus.mem_cenb_o = 1'b1;
    bus.mem_wenb_o = 1'b1;
    bus.mem_addr_o = '0;
    bus.mem_data_o = '0;
    if (wr_win) begin
      bus.mem_cenb_o = 1'b0;
      bus.mem_wenb_o = 1'b0;
      bus.mem_addr_o = head.addr;
      bus.mem_data_o = head.data;
    end else if (rd_win) begin
      bus.mem_cenb_o = 1'b0;
      bus.mem_addr_o = bus.rd_addr_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_win;
      if (clear_i)   overflow_q <= 1'b0;
      else if (drop) overflow_q <= 1'b1;
    end
  end

  assign bus.rd_valid_o = rd_valid_q;
  assign bus.rd_data_o  = bus.mem_data_i;
  assign fifo_count_o   = count;
  assign overflow_o     = overflow_q;
  assign idle_o         = empty && !rd_valid_q && !bus.wr_valid_i;
endmodule

// File: tb/tb_ob_port_arbiter.sv
// Directed bench for ob_port_arbiter with a behavioural 1-cycle-latency SRAM.
module tb_ob_port_arbiter;
  import ob_arb_pkg::*;

  logic              clk_i = 1'b0;
  logic              rstn_i = 1'b0;
  logic              clear_i = 1'b0;
  logic [CNT_W-1:0]  fifo_count_o;
  logic              idle_o, overflow_o;

  ob_port_arbiter_if bus ();

  ob_port_arbiter u_dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .clear_i      (clear_i),
    .bus          (bus),
    .fifo_count_o (fifo_count_o),
    .idle_o       (idle_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  // SRAM model with a backdoor preload port.
  logic [DW-1:0] sram [O_SIZE];
  logic [DW-1:0] sram_rdata = '0;
  int unsigned   sram_wr_cnt = 0;
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  always @(posedge clk_i) begin
    if (bd_we) sram[bd_addr] <= bd_data;
    if (!bus.mem_cenb_o) begin
      if (!bus.mem_wenb_o) begin
        sram[bus.mem_addr_o] <= bus.mem_data_o;
        sram_wr_cnt          <= sram_wr_cnt + 1;
      end else begin
        sram_rdata <= sram[bus.mem_addr_o];
      end
    end
  end
  assign bus.mem_data_i = sram_rdata;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_valid_i = 1'b0;
    bus.wr_addr_i  = '0;
    bus.wr_data_i  = '0;
    bus.rd_req_i   = 1'b0;
    bus.rd_addr_i  = '0;
    clear_i        = 1'b0;
  endtask

  task automatic drive_wr(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wr_valid_i = v;
    bus.wr_addr_i  = a;
    bus.wr_data_i  = d;
  endtask

  task automatic drive_rd(input logic r, input logic [AW-1:0] a);
    bus.rd_req_i  = r;
    bus.rd_addr_i = a;
  endtask

  int unsigned wr_base;

  initial begin
    idle_inputs();
    #12;
    check("rst_count", fifo_count_o, 0);
    check("rst_cenb", bus.mem_cenb_o, 1);
    check("rst_wenb", bus.mem_wenb_o, 1);
    check("rst_addr", bus.mem_addr_o, 0);
    check("rst_data", bus.mem_data_o, 0);
    check("rst_gnt", bus.rd_gnt_o, 0);
    check("rst_rvalid", bus.rd_valid_o, 0);
    check("rst_ovf", overflow_o, 0);
    check("rst_idle", idle_o, 1);
    rstn_i = 1'b1;

    // Writes only: three pushes, each drained the following cycle.
    cyc();
    drive_wr(1'b1, 8'd0, 32'h11111111); #1;
    check("w_nobypass_cenb", bus.mem_cenb_o, 1);
    cyc();
    drive_wr(1'b1, 8'd1, 32'h22222222); #1;
    check("w1_cenb", bus.mem_cenb_o, 0);
    check("w1_wenb", bus.mem_wenb_o, 0);
    check("w1_addr", bus.mem_addr_o, 0);
    check("w1_data", bus.mem_data_o, 32'h11111111);
    check("w1_count", fifo_count_o, 1);
    cyc();
    drive_wr(1'b1, 8'd2, 32'h33333333); #1;
    check("w2_addr", bus.mem_addr_o, 1);
    check("w2_count", fifo_count_o, 1);
    cyc();
    drive_wr(1'b0, 8'd0, 32'h0); #1;
    check("w3_addr", bus.mem_addr_o, 2);
    check("w3_data", bus.mem_data_o, 32'h33333333);
    check("w3_count", fifo_count_o, 1);
    cyc(); #1;
    check("w_idle", idle_o, 1);
    check("w_count0", fifo_count_o, 0);
    check("w_sram0", sram[0], 32'h11111111);
    check("w_sram1", sram[1], 32'h22222222);
    check("w_sram2", sram[2], 32'h33333333);

    // Read only from a preloaded word.
    bd_we = 1'b1; bd_addr = 8'd5; bd_data = 32'hA5A5A5A5;
    cyc();
    bd_we = 1'b0;
    drive_rd(1'b1, 8'd5); #1;
    check("r_gnt", bus.rd_gnt_o, 1);
    check("r_cenb", bus.mem_cenb_o, 0);
    check("r_wenb", bus.mem_wenb_o, 1);
    check("r_addr", bus.mem_addr_o, 5);
    cyc();
    drive_rd(1'b0, 8'd0); #1;
    check("r_valid", bus.rd_valid_o, 1);
    check("r_data", bus.rd_data_o, 32'hA5A5A5A5);

    // Contention: reads win until the watermark, then writes take the port.
    cyc();
    drive_rd(1'b1, 8'd100); drive_wr(1'b1, 8'd10, 32'h1000000A); #1;
    check("c0_gnt", bus.rd_gnt_o, 1);
    cyc();
    drive_rd(1'b1, 8'd101); drive_wr(1'b1, 8'd11, 32'h1000000B); #1;
    check("c1_gnt", bus.rd_gnt_o, 1);
    cyc();
    drive_rd(1'b1, 8'd102); drive_wr(1'b1, 8'd12, 32'h1000000C); #1;
    check("c2_gnt", bus.rd_gnt_o, 1);
    check("c2_count", fifo_count_o, 2);
    cyc();
    drive_wr(1'b1, 8'd13, 32'h1000000D); #1;
    check("c3_count", fifo_count_o, 3);
    check("c3_gnt", bus.rd_gnt_o, 0);
    check("c3_wenb", bus.mem_wenb_o, 0);
    check("c3_addr", bus.mem_addr_o, 10);
    cyc();
    drive_wr(1'b0, 8'd0, 32'h0); #1;
    check("c4_gnt", bus.rd_gnt_o, 0);
    check("c4_addr", bus.mem_addr_o, 11);
    cyc(); #1;
    check("c5_count", fifo_count_o, 2);
    check("c5_gnt", bus.rd_gnt_o, 1);
    check("c5_addr", bus.mem_addr_o, 102);
    cyc();
    drive_rd(1'b0, 8'd0); #1;
    check("c6_addr", bus.mem_addr_o, 12);
    cyc(); #1;
    check("c7_addr", bus.mem_addr_o, 13);
    cyc(); #1;
    check("c_ovf", overflow_o, 0);
    check("c_sram10", sram[10], 32'h1000000A);
    check("c_sram11", sram[11], 32'h1000000B);
    check("c_sram12", sram[12], 32'h1000000C);
    check("c_sram13", sram[13], 32'h1000000D);

    // Read-after-write to the same address.
    drive_wr(1'b1, 8'd7, 32'hDEADBEEF);
    cyc();
    drive_wr(1'b0, 8'd0, 32'h0); drive_rd(1'b1, 8'd7); #1;
    check("raw_hold_gnt", bus.rd_gnt_o, 0);
    check("raw_drain_addr", bus.mem_addr_o, 7);
    check("raw_drain_wenb", bus.mem_wenb_o, 0);
    cyc(); #1;
    check("raw_gnt", bus.rd_gnt_o, 1);
    cyc();
    drive_rd(1'b0, 8'd0); #1;
    check("raw_valid", bus.rd_valid_o, 1);
    check("raw_data", bus.rd_data_o, 32'hDEADBEEF);

    // Flush with two entries pending behind a stream of reads.
    wr_base = sram_wr_cnt;
    cyc();
    drive_rd(1'b1, 8'd50); drive_wr(1'b1, 8'd20, 32'h20202020); #1;
    cyc();
    drive_wr(1'b1, 8'd21, 32'h21212121); #1;
    cyc();
    drive_wr(1'b0, 8'd0, 32'h0); clear_i = 1'b1; #1;
    check("clr_count_before", fifo_count_o, 2);
    check("clr_gnt", bus.rd_gnt_o, 1);
    cyc();
    clear_i = 1'b0; drive_rd(1'b0, 8'd0); #1;
    check("clr_count", fifo_count_o, 0);
    check("clr_cenb", bus.mem_cenb_o, 1);
    check("clr_rvalid", bus.rd_valid_o, 1);
    check("clr_ovf", overflow_o, 0);
    cyc(); cyc(); #1;
    check("clr_no_writes", sram_wr_cnt - wr_base, 0);

    // Reset while three entries wait to drain.
    wr_base = sram_wr_cnt;
    drive_rd(1'b1, 8'd60); drive_wr(1'b1, 8'd30, 32'h30303030);
    cyc();
    drive_wr(1'b1, 8'd31, 32'h31313131);
    cyc();
    drive_wr(1'b1, 8'd32, 32'h32323232);
    cyc();
    drive_wr(1'b0, 8'd0, 32'h0); drive_rd(1'b0, 8'd0); #1;
    check("rm_count", fifo_count_o, 3);
    check("rm_cenb_busy", bus.mem_cenb_o, 0);
    check("rm_rvalid_before", bus.rd_valid_o, 1);
    rstn_i = 1'b0; #1;
    check("rm_cenb", bus.mem_cenb_o, 1);
    check("rm_count0", fifo_count_o, 0);
    check("rm_rvalid", bus.rd_valid_o, 0);
    cyc();
    rstn_i = 1'b1;
    cyc(); #1;
    check("rm_no_writes", sram_wr_cnt - wr_base, 0);
    drive_wr(1'b1, 8'd40, 32'h40404040);
    cyc();
    drive_wr(1'b0, 8'd0, 32'h0); #1;
    check("rm_post_addr", bus.mem_addr_o, 40);
    cyc();
    drive_rd(1'b1, 8'd40); #1;
    check("rm_post_gnt", bus.rd_gnt_o, 1);
    cyc();
    drive_rd(1'b0, 8'd0); #1;
    check("rm_post_data", bus.rd_data_o, 32'h40404040);
    check("rm_post_valid", bus.rd_valid_o, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
